// File: rtl/serial_deser.sv
// ---------------------------------------------------------------------------
// serial_deser
//   Serial-to-parallel deserializer fed by the registered bit of dff_p.
//   Shifts W qualified serial bits into a word and presents the finished word
//   on a one-entry output buffer with a valid/ready handshake. A word that
//   completes while the buffer is full and not being popped is dropped and
//   flagged on the sticky ovf output.
//
// Parameters
//   W          word width, 2..16
//   MSB_FIRST  1: first received bit lands in data[W-1]; 0: in data[0]
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   di        in   serial bit (dff_p output)
//   di_vld    in   di is sampled on this edge when high
//   clr       in   synchronous clear of partial word, buffer state and ovf
//   data      out  [W-1:0] buffered word
//   data_vld  out  buffer holds a word
//   data_rdy  in   consumer pops the word when data_vld is also high
//   bit_cnt   out  [3:0] bits held in the partial word (0..W-1)
//   ovf       out  sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module serial_deser #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         di,
    input  logic         di_vld,
    input  logic         clr,
    output logic [W-1:0] data,
    output logic         data_vld,
    input  logic         data_rdy,
    output logic [3:0]   bit_cnt,
    output logic         ovf
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [3:0] LAST  = 4'(W - 1);

    logic [W-1:0] sh;
    logic [W-1:0] sh_nxt;
    logic [0:0]   state;
    logic         done;

    // Shift-register value with the current bit applied; on the completing
    // edge this is also the finished word.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_nxt = {sh[W-2:0], di};
        end else begin : g_lsb
            assign sh_nxt = {di, sh[W-1:1]};
        end
    endgenerate

    assign done     = di_vld && (bit_cnt == LAST);
    assign data_vld = (state == FULL);

    // Shift path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (di_vld) begin
            if (done) begin
                // Word leaves via sh_nxt into the buffer; start a fresh one.
                sh      <= '0;
                bit_cnt <= '0;
            end else begin
                sh      <= sh_nxt;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Output buffer. data is deliberately left alone by clr and by a pop so
    // the last word stays readable; only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= EMPTY;
            ovf   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (done) begin
                        state <= FULL;
                        data  <= sh_nxt;
                    end
                end
                FULL: begin
                    if (done) begin
                        // Pop and completion together refill with no bubble;
                        // without a pop the held word wins and the new one
                        // is dropped.
                        if (data_rdy) data <= sh_nxt;
                        else          ovf  <= 1'b1;
                    end else if (data_rdy) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_deser.sv
// ---------------------------------------------------------------------------
// tb_serial_deser
//   Bench for serial_deser. Two instances share all inputs: one MSB-first,
//   one LSB-first. Expected words are queued when sent and compared when the
//   DUT hands them over (data_vld && data_rdy). A table of words is streamed,
//   followed by directed sequences for dff_p feeding, overrun, pop+complete,
//   async reset and di_vld gaps.
// ---------------------------------------------------------------------------
module tb_serial_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       di;
    logic       di_drv;
    logic       di_vld;
    logic       clr;
    logic       data_rdy;
    logic [7:0] data_m, data_l;
    logic       vld_m, vld_l;
    logic [3:0] cnt_m, cnt_l;
    logic       ovf_m, ovf_l;

    // Stand-in for dff_p: a plain bit register whose output can feed di.
    logic       tgl_src;
    logic       dff_q;
    logic       use_dff;
    always_ff @(posedge clk) dff_q <= tgl_src;
    assign di = use_dff ? dff_q : di_drv;

    always #5 clk = ~clk;

    serial_deser #(.W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .di(di), .di_vld(di_vld), .clr(clr),
        .data(data_m), .data_vld(vld_m), .data_rdy(data_rdy),
        .bit_cnt(cnt_m), .ovf(ovf_m)
    );

    serial_deser #(.W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .di(di), .di_vld(di_vld), .clr(clr),
        .data(data_l), .data_vld(vld_l), .data_rdy(data_rdy),
        .bit_cnt(cnt_l), .ovf(ovf_l)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: a handshake will occur on the coming edge; compare the word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && data_rdy === 1'b1) begin
            if (vld_m === 1'b1) begin
                if (q_m.size() == 0) chk("sb_m_unexpected", 32'(data_m), 32'hFFFF_FFFF);
                else                 chk("sb_m_word", 32'(data_m), 32'(q_m.pop_front()));
            end
            if (vld_l === 1'b1) begin
                if (q_l.size() == 0) chk("sb_l_unexpected", 32'(data_l), 32'hFFFF_FFFF);
                else                 chk("sb_l_word", 32'(data_l), 32'(q_l.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Send bits w[hi] down to w[lo] on consecutive edges, then drop di_vld.
    task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            di_drv = w[i];
            di_vld = 1'b1;
            tick();
        end
        di_vld = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] m, input logic [7:0] l);
        q_m.push_back(m);
        q_l.push_back(l);
    endtask

    typedef struct {
        logic [7:0] word;   // bit sequence, sent word[7] first
        logic [7:0] exp_m;  // expected word, MSB-first instance
        logic [7:0] exp_l;  // expected word, LSB-first instance
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'hB2, 8'hB2, 8'h4D};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF};
        tbl[2] = '{8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'h80, 8'h80, 8'h01};
        tbl[4] = '{8'h01, 8'h01, 8'h80};
        tbl[5] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[6] = '{8'h3C, 8'h3C, 8'h3C};
        tbl[7] = '{8'h55, 8'h55, 8'hAA};
        tbl[8] = '{8'hF0, 8'hF0, 8'h0F};
        tbl[9] = '{8'h12, 8'h12, 8'h48};

        rst_n    = 1'b0;
        di_drv   = 1'b0;
        di_vld   = 1'b0;
        clr      = 1'b0;
        data_rdy = 1'b0;
        tgl_src  = 1'b0;
        use_dff  = 1'b0;

        // Reset state
        #12;
        chk("rst_data_m", 32'(data_m), 32'h0);
        chk("rst_vld_m",  32'(vld_m),  32'h0);
        chk("rst_cnt_m",  32'(cnt_m),  32'h0);
        chk("rst_ovf_m",  32'(ovf_m),  32'h0);
        chk("rst_data_l", 32'(data_l), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table: stream each word with the consumer always ready
        data_rdy = 1'b1;
        foreach (tbl[k]) begin
            expect_word(tbl[k].exp_m, tbl[k].exp_l);
            send_bits(tbl[k].word, 7, 0);
            chk($sformatf("tbl%0d_vld", k),    32'(vld_m),  32'h1);
            chk($sformatf("tbl%0d_data_m", k), 32'(data_m), 32'(tbl[k].exp_m));
            chk($sformatf("tbl%0d_data_l", k), 32'(data_l), 32'(tbl[k].exp_l));
            chk($sformatf("tbl%0d_cnt", k),    32'(cnt_m),  32'h0);
            tick();
            chk($sformatf("tbl%0d_vld_drop", k), 32'(vld_m), 32'h0);
            chk($sformatf("tbl%0d_ovf", k),      32'(ovf_m), 32'h0);
        end

        // Fed by the bit register with a toggling source starting at 0
        tick();                   // register now holds 0
        tgl_src = 1'b1;
        use_dff = 1'b1;
        di_vld  = 1'b1;
        for (int w = 0; w < 3; w++) expect_word(8'h55, 8'hAA);
        for (int i = 1; i <= 24; i++) begin
            tick();
            tgl_src = ~tgl_src;
            chk($sformatf("dff_vld_c%0d", i), 32'(vld_m), (i % 8 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("dff_ovf_c%0d", i), 32'(ovf_m), 32'h0);
        end
        di_vld  = 1'b0;
        use_dff = 1'b0;
        tick();
        chk("dff_drained", 32'(vld_m), 32'h0);

        // Backpressure and overrun
        data_rdy = 1'b0;
        expect_word(8'hA5, 8'hA5);
        send_bits(8'hA5, 7, 0);
        chk("bp_vld",    32'(vld_m),  32'h1);
        chk("bp_data",   32'(data_m), 32'hA5);
        chk("bp_ovf0",   32'(ovf_m),  32'h0);
        send_bits(8'h3C, 7, 1);
        chk("bp_ovf_pre", 32'(ovf_m), 32'h0);
        send_bits(8'h3C, 0, 0);   // completes 3C while full: dropped
        chk("bp_hold_data", 32'(data_m), 32'hA5);
        chk("bp_hold_vld",  32'(vld_m),  32'h1);
        chk("bp_ovf_set",   32'(ovf_m),  32'h1);
        chk("bp_ovf_set_l", 32'(ovf_l),  32'h1);
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        chk("bp_pop_vld", 32'(vld_m), 32'h0);
        chk("bp_ovf_sticky", 32'(ovf_m), 32'h1);
        send_bits(8'hE0, 7, 5);   // partial word before clr
        chk("bp_cnt_partial", 32'(cnt_m), 32'h3);
        chk("bp_ovf_sticky2", 32'(ovf_m), 32'h1);
        clr = 1'b1;
        di_drv = 1'b1;
        di_vld = 1'b1;            // ignored under clr
        tick();
        clr    = 1'b0;
        di_vld = 1'b0;
        chk("clr_ovf",  32'(ovf_m),  32'h0);
        chk("clr_cnt",  32'(cnt_m),  32'h0);
        chk("clr_vld",  32'(vld_m),  32'h0);
        chk("clr_data", 32'(data_m), 32'hA5);

        // Pop and completion on the same edge
        expect_word(8'h11, 8'h88);
        send_bits(8'h11, 7, 0);
        chk("pc_full", 32'(vld_m), 32'h1);
        expect_word(8'h22, 8'h44);
        send_bits(8'h22, 7, 1);
        data_rdy = 1'b1;
        send_bits(8'h22, 0, 0);
        chk("pc_data",   32'(data_m), 32'h22);
        chk("pc_data_l", 32'(data_l), 32'h44);
        chk("pc_vld",    32'(vld_m),  32'h1);
        chk("pc_ovf",    32'(ovf_m),  32'h0);
        tick();
        chk("pc_drained", 32'(vld_m), 32'h0);

        // Async reset mid-word with a buffered word held
        data_rdy = 1'b0;
        send_bits(8'h77, 7, 0);   // held, never popped; reset discards it
        send_bits(8'hFF, 7, 3);
        chk("ar_pre_cnt", 32'(cnt_m), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_data", 32'(data_m), 32'h0);
        chk("ar_vld",  32'(vld_m),  32'h0);
        chk("ar_cnt",  32'(cnt_m),  32'h0);
        chk("ar_ovf",  32'(ovf_m),  32'h0);
        #1;
        rst_n = 1'b1;

        // Fresh word F0 with a 3-cycle gap between bits 4 and 5
        data_rdy = 1'b1;
        expect_word(8'hF0, 8'h0F);
        send_bits(8'hF0, 7, 4);
        chk("gap_cnt0", 32'(cnt_m), 32'h4);
        for (int g = 1; g <= 3; g++) begin
            tick();
            chk($sformatf("gap_cnt%0d", g), 32'(cnt_m), 32'h4);
            chk($sformatf("gap_vld%0d", g), 32'(vld_m), 32'h0);
        end
        send_bits(8'hF0, 3, 0);
        chk("gap_data",   32'(data_m), 32'hF0);
        chk("gap_data_l", 32'(data_l), 32'h0F);
        chk("gap_vld",    32'(vld_m),  32'h1);
        tick();
        chk("gap_drained", 32'(vld_m), 32'h0);

        chk("sb_m_empty", 32'(q_m.size()), 32'h0);
        chk("sb_l_empty", 32'(q_l.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1, "timeout");
    end

endmodule
